// File: rtl/reg_scoreboard.sv
// Decode-stage pending-write scoreboard for the 8x16 register file: one in-flight counter per register.
// stall is combinational from current counts and decode/writeback inputs; busy and err are registered.
module reg_scoreboard #(
  parameter int CNT_W  = 2,
  parameter bit BYPASS = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic       issue_wr,
  input  logic [2:0] issue_wrsel,
  input  logic       src1_used,
  input  logic [2:0] src1sel,
  input  logic       src2_used,
  input  logic [2:0] src2sel,
  input  logic       wb_write,
  input  logic [2:0] wb_regsel,
  output logic       stall,
  output logic [7:0] busy,
  output logic       err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic             err_q, err_d;

  logic       haz1, haz2, cap, stall_c, acc;
  logic [7:0] inc, dec;

  always_comb begin
    haz1 = src1_used && (cnt_q[src1sel] != '0);
    haz2 = src2_used && (cnt_q[src2sel] != '0);
    // With forwarding, the final outstanding write landing this cycle satisfies the read.
    if (BYPASS && wb_write && (wb_regsel == src1sel) && (cnt_q[src1sel] == CNT_ONE)) haz1 = 1'b0;
    if (BYPASS && wb_write && (wb_regsel == src2sel) && (cnt_q[src2sel] == CNT_ONE)) haz2 = 1'b0;
    cap     = issue_wr && (cnt_q[issue_wrsel] == CNT_MAX);
    stall_c = !rst && issue_valid && (haz1 || haz2 || cap);
    acc     = issue_valid && issue_wr && !stall_c;
  end

  always_comb begin
    err_d = err_q;
    inc   = '0;
    dec   = '0;
    for (int r = 0; r < 8; r++) begin
      inc[r]   = acc && (issue_wrsel == 3'(r));
      dec[r]   = wb_write && (wb_regsel == 3'(r));
      cnt_d[r] = cnt_q[r];
      if (dec[r] && (cnt_q[r] == '0)) err_d = 1'b1;
      if (inc[r] && !dec[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec[r] && !inc[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 8; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < 8; r++) cnt_q[r] <= cnt_d[r];
      err_q <= err_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < 8; r++) busy[r] = (cnt_q[r] != '0);
  end

  assign stall = stall_c;
  assign err   = err_q;

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Decode-stage pending-write tracker that sits beside the 8x16 register file.
- Records every issued instruction that will write a register and retires the record when the writeback stage asserts the register-file write.
- Raises a stall whenever the instruction in decode reads a register that still has a write outstanding.
- Keeps one in-flight counter per architectural register (R0-R7), so several outstanding writes to the same register are handled.

Parameters:
CNT_W, 2, width of each per-register in-flight counter; maximum outstanding writes per register = 2^CNT_W - 1.
BYPASS, 0, 1 = register file forwards write data to reads in the same cycle, so a source whose last outstanding write is retiring this cycle does not stall; 0 = it stalls.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
issue_valid  input  1  instruction in decode is valid
issue_wr  input  1  the decode instruction writes a register
issue_wrsel  input  3  destination register of the decode instruction
src1_used  input  1  decode instruction reads src1
src1sel  input  3  first source register (same value as the rf read1regsel)
src2_used  input  1  decode instruction reads src2
src2sel  input  3  second source register (same value as the rf read2regsel)
wb_write  input  1  writeback is writing the register file this cycle (same as the rf write)
wb_regsel  input  3  register being written back (same as the rf writeregsel)
stall  output  1  decode must hold; the issue is not accepted this cycle
busy  output  8  bit r = 1 when count[r] != 0
err  output  1  sticky protocol error

Behaviour:
- State: count[0..7], each CNT_W bits; err_q, 1 bit.
- Reset (rst=1 at a clock edge): all counts = 0, err = 0, busy = 8'h00.
  - While rst=1, stall = 0 and no count updates occur.
  - Reset mid-operation discards all pending records; inputs present in the reset cycle are ignored.
- Hazard term per source s: haz_s = src_s_used & (count[sel_s] != 0).
  - When BYPASS=1, haz_s is masked if wb_write & (wb_regsel == sel_s) & (count[sel_s] == 1).
- Capacity term: cap = issue_wr & (count[issue_wrsel] == max).
- stall = issue_valid & (haz_1 | haz_2 | cap). Purely combinational from current state and inputs; zero latency.
- Issue accept: acc = issue_valid & issue_wr & ~stall.
- Retire: ret = wb_write.
- Next-count per register r, with inc = acc & (issue_wrsel == r) and dec = ret & (wb_regsel == r):
  - inc & ~dec: count + 1.
  - dec & ~inc: count - 1.
  - both or neither: unchanged.
- Underflow: dec with count[r] == 0 leaves count at 0 and sets err.
- err is sticky until reset and has no other effect on operation.
- Self-dependency: an instruction with dest == src (e.g. ADD R3,R3,R1) stalls only on the source check, using the old count. Its own increment never causes it to stall.
- A retire to R_x in the same cycle as an issue to R_x leaves count[R_x] unchanged. This is required to hold even when count = max, provided the capacity check passes.
  - The capacity check uses the pre-update count, so at count = max the issue stalls, even if a retire is present.
- issue_wr with issue_valid=0 has no effect.
- src_used=0 ignores the corresponding sel.
- All 8 registers are tracked identically; R0 is not special.
- busy reflects registered counts only (no combinational path from inputs).

Test Plan:
1. Reset, then issue a write to R2 (issue_valid=1, issue_wr=1, issue_wrsel=2) -> next cycle busy=8'h04, stall=0 on the issue cycle. Then src1sel=2, src1_used=1 -> stall=1. Then wb_write=1, wb_regsel=2 -> busy=8'h00 after the edge; stall drops the following cycle (BYPASS=0), or in the same cycle (BYPASS=1).
2. Issue three writes to R5 back to back, then a fourth -> counts 1,2,3; the fourth issue stalls (cap), count stays 3. Three retires to R5 -> count 0, busy[5]=0.
3. count[4]=1; same cycle issue to R4 and retire R4, with no source hazard -> stall=0, count[4] stays 1.
4. wb_write=1, wb_regsel=6 with count[6]=0 -> err=1 next cycle, count[6]=0. err remains 1 across later traffic until rst.
5. Counts R1=1, R3=2; assert rst for one cycle while issue_valid=1 writes R1 -> after the edge all counts 0, busy=0, err=0, and the issue is not recorded.
6. src2_used=0, src2sel=1 with busy[1]=1, and src1 clean -> stall=0. issue_valid=0 with issue_wr=1 -> no count change.
